// File: rtl/par2ser_shift_pkg.sv
// Shared types for the parallel-to-serial front end and its shift stage.
package par2ser_shift_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;  // LSB first
  localparam logic DIR_LEFT  = 1'b1;  // MSB first

endpackage

// File: rtl/par2ser_shift_if.sv
// Upstream word handshake: valid/ready with the word and its shift direction.
interface par2ser_shift_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic [N-1:0] in_data;
  logic         dir;
  logic         in_ready;

  modport master (output in_valid, output in_data, output dir, input in_ready);
  modport slave  (input in_valid, input in_data, input dir, output in_ready);

endinterface

// File: rtl/par2ser_shift_bit_cnt.sv
// Loadable down-counter tracking the bits still to follow the current one.
module par2ser_shift_bit_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority over decrement so a back-to-back word restarts cleanly.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/par2ser_shift.sv
// Parallel-to-serial converter: accepts an N-bit word and streams it MSB- or LSB-first.
module par2ser_shift
  import par2ser_shift_pkg::*;
#(
  parameter  int N  = 32,
  localparam int CW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  par2ser_shift_if.slave       up,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 busy,
  output logic [CW-1:0]        bit_cnt
);

  state_e       state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic         dir_q, dir_d;

  logic          cnt_load_s;
  logic          cnt_dec_s;
  logic          cnt_zero_s;
  logic [CW-1:0] cnt_s;
  logic          in_ready_s;
  logic          busy_s;
  logic          ser_bit_s;

  par2ser_shift_bit_cnt #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load_s),
    .load_val (CW'(N - 1)),
    .dec      (cnt_dec_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  assign busy_s     = (state_q == SHIFT);
  // Ready on the last enabled bit too, so the next word follows with no gap.
  assign in_ready_s = (state_q == IDLE) | (busy_s & en & cnt_zero_s);
  assign ser_bit_s  = (dir_q == DIR_LEFT) ? sreg_q[N-1] : sreg_q[0];

  // Next-state, shift and counter control.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    dir_d      = dir_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (up.in_valid) begin
          sreg_d     = up.in_data;
          dir_d      = up.dir;
          cnt_load_s = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_d = SHIFT;
        end else if (!cnt_zero_s) begin
          sreg_d    = (dir_q == DIR_LEFT) ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};
          cnt_dec_s = 1'b1;
        end else if (up.in_valid) begin
          sreg_d     = up.in_data;
          dir_d      = up.dir;
          cnt_load_s = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register and latched direction.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  end

  assign up.in_ready  = in_ready_s;
  assign busy         = busy_s;
  assign ser_valid    = busy_s & en;
  assign ser_out      = busy_s & ser_bit_s;
  assign frame_start  = busy_s & en & (cnt_s == CW'(N - 1));
  assign frame_end    = busy_s & en & cnt_zero_s;
  assign bit_cnt      = cnt_s;

endmodule

// File: tb/tb_par2ser_shift.sv
// Scoreboard bench for par2ser_shift with N=8: expected bits queued on accept, checked as they stream.
module tb_par2ser_shift;

  localparam int N = 8;

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       en;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;
  logic [2:0] bit_cnt;

  int   checks;
  int   errors;
  exp_t sb[$];

  par2ser_shift_if #(.N(N)) bif ();

  par2ser_shift #(.N(N)) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .up          (bif),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every valid serial bit is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!clr && ser_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got bit %0b, required no valid bit", ser_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({ser_out, frame_start, frame_end} !== {e.b, e.fs, e.fe}) begin
          errors++;
          $display("FAIL stream_bit: got out/fs/fe %b%b%b, required %b%b%b",
                   ser_out, frame_start, frame_end, e.b, e.fs, e.fe);
        end
      end
    end
  end

  task automatic push_word(input logic [N-1:0] w, input logic d);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.b  = d ? w[N-1-i] : w[i];
      e.fs = (i == 0);
      e.fe = (i == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait for the handshake; leaves in_valid asserted.
  task automatic send_word(input logic [N-1:0] w, input logic d, output bit ok);
    logic acc;
    ok = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = w;
    bif.dir      = d;
    for (int t = 0; t < 32 && !ok; t++) begin
      @(negedge clk);
      acc = bif.in_ready;
      tick();
      if (acc) ok = 1'b1;
    end
    if (ok) push_word(w, d);
  endtask

  task automatic wait_idle(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cycles++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    en = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.dir = 1'b0;
    #12;
    checks++;
    if ({busy, ser_valid, ser_out, frame_start, frame_end, bit_cnt} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {busy, ser_valid, ser_out, frame_start, frame_end, bit_cnt});
    end
    tick();
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", bif.in_ready, busy);
    end
    tick();
  endtask

  task automatic test_dir_left();
    bit ok;
    int cyc;
    send_word(8'hC1, 1'b1, ok);
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL left_accept: got no accept, required accept"); end
    wait_idle(ok, cyc);
    checks++;
    if (!ok || cyc != N) begin
      errors++;
      $display("FAIL left_length: got %0d busy cycles (idle=%0b), required %0d", cyc, ok, N);
    end
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL left_done: got ready=%b pending=%0d, required ready=1 pending=0", bif.in_ready, sb.size());
    end
    tick();
  endtask

  task automatic test_dir_right();
    bit ok;
    int cyc;
    send_word(8'hC1, 1'b0, ok);
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL right_accept: got no accept, required accept"); end
    for (int i = 0; i < N; i++) begin
      bif.dir = ~bif.dir;
      bif.in_data = 8'($urandom);
      tick();
    end
    wait_idle(ok, cyc);
    checks++;
    if (!ok || cyc != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL right_done: got extra=%0d pending=%0d, required extra=0 pending=0", cyc, sb.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    int cyc;
    send_word(8'hC1, 1'b1, ok);
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_accept: got no accept, required accept"); end
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0 || bit_cnt !== 3'd4 || busy !== 1'b1 || bif.in_ready !== 1'b0 ||
          frame_end !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b cnt=%0d busy=%b ready=%b fe=%b, required 0 4 1 0 0",
                 ser_valid, bit_cnt, busy, bif.in_ready, frame_end);
      end
      tick();
    end
    en = 1'b1;
    wait_idle(ok, cyc);
    checks++;
    if (!ok || (cyc + 6) != 11 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_total: got %0d cycles pending=%0d, required 11 pending=0", cyc + 6, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_word(8'hC1, 1'b1, ok);
    bif.in_data = 8'h3E;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_accept: got no accept, required accept"); end
    for (int c = 1; c <= 2 * N; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap: got ser_valid=%b at cycle %0d, required 1", ser_valid, c);
      end
      if (c == N) begin
        checks++;
        if (frame_end !== 1'b1 || bif.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_last: got fe=%b ready=%b, required fe=1 ready=1", frame_end, bif.in_ready);
        end
      end else if (c < N) begin
        checks++;
        if (bif.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready: got ready=%b at cycle %0d, required 0", bif.in_ready, c);
        end
      end else if (c == N + 1) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("FAIL b2b_start: got fs=%b at cycle %0d, required 1", frame_start, c);
        end
      end
      tick();
      if (c == N) begin
        push_word(8'h3E, 1'b1);
        bif.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_done: got busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
    tick();
  endtask

  task automatic test_ignore_valid();
    bit ok;
    int cyc;
    send_word(8'hC1, 1'b1, ok);
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_accept: got no accept, required accept"); end
    tick();
    bif.in_valid = 1'b1;
    bif.in_data = 8'hAA;
    bif.dir = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ign_ready: got ready=%b, required 0", bif.in_ready);
    end
    tick();
    bif.in_valid = 1'b0;
    wait_idle(ok, cyc);
    checks++;
    if (!ok || cyc != N - 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL ign_done: got %0d cycles pending=%0d, required %0d pending=0", cyc, sb.size(), N - 2);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    send_word(8'hFF, 1'b1, ok);
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL mrst_accept: got no accept, required accept"); end
    tick();
    tick();
    #1;
    clr = 1'b1;
    #1;
    checks++;
    if ({busy, ser_valid, ser_out, frame_start, frame_end, bit_cnt} !== 8'b0) begin
      errors++;
      $display("FAIL mrst_async: got %b, required 00000000",
               {busy, ser_valid, ser_out, frame_start, frame_end, bit_cnt});
    end
    sb.delete();
    tick();
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mrst_after: got valid=%b ready=%b, required valid=0 ready=1", ser_valid, bif.in_ready);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_dir_left();
    test_dir_right();
    test_stall();
    test_back_to_back();
    test_ignore_valid();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
